// File: rtl/traffic_pkg.sv
// Shared types for the intersection scheduler: light codes, phase codes
// and the phase-to-light decode used by the top-level controller.
package traffic_pkg;

    localparam logic [1:0] OFF    = 2'b00;
    localparam logic [1:0] RED    = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;
    localparam logic [1:0] GREEN  = 2'b11;

    typedef enum logic [2:0] {
        ALL_RED_A = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_B = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6,
        FLASH     = 3'd7
    } phase_e;

    typedef struct packed {
        logic [1:0] ns;
        logic [1:0] ew;
        logic       walk;
    } lights_t;

    // flash_off selects the dark half of the fault flash; it is held low
    // when the conflict monitor is not built, so FLASH then shows all red.
    function automatic lights_t decode(phase_e ph, logic flash_off);
        lights_t l;
        l = '{ns: RED, ew: RED, walk: 1'b0};
        case (ph)
            NS_GREEN:  l.ns = GREEN;
            NS_YELLOW: l.ns = YELLOW;
            EW_GREEN:  l.ew = GREEN;
            EW_YELLOW: l.ew = YELLOW;
            PED_WALK:  l.walk = 1'b1;
            FLASH: begin
                l.ns = flash_off ? OFF : RED;
                l.ew = flash_off ? OFF : RED;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for phase durations; advances only on tick.
// Ports: clk_i, rst_ni (sync, active-low), tick_i, load_i, load_val_i,
//        count_o (current value), zero_o (count==0), expire_o (zero & tick).
module phase_timer #(
    parameter int              W       = 8,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         tick_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] count_o,
    output logic         zero_o,
    output logic         expire_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = load_val_i;
        else if (tick_i && !zero_o)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            count_q <= RST_VAL;
        else
            count_q <= count_d;
    end

    assign count_o  = count_q;
    assign zero_o   = (count_q == '0);
    assign expire_o = zero_o & tick_i;

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road intersection controller: NS rests in green, EW is served on
// demand with gap-out, pedestrians get an exclusive all-red walk phase.
// Ports: clk, rst_n (sync, active-low), tick, ew_car, ped_req in;
//        ns_light, ew_light, ped_walk, ped_ack, phase, fault out.
// Optional: define CONFLICT_MONITOR_EN for the latched fault / FLASH mode.
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int TIMER_W       = 8,
    parameter int NS_MIN_GREEN  = 50,
    parameter int EW_MIN_GREEN  = 10,
    parameter int EW_MAX_GREEN  = 30,
    parameter int YELLOW_TIME   = 5,
    parameter int ALL_RED_TIME  = 2,
    parameter int PED_WALK_TIME = 20,
    parameter int FLASH_HALF    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       ped_walk,
    output logic       ped_ack,
    output logic [2:0] phase,
    output logic       fault
);

    localparam logic [TIMER_W-1:0] T_ARED  = TIMER_W'(ALL_RED_TIME - 1);
    localparam logic [TIMER_W-1:0] T_NSG   = TIMER_W'(NS_MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_EWG   = TIMER_W'(EW_MAX_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_YEL   = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] T_WALK  = TIMER_W'(PED_WALK_TIME - 1);
    localparam logic [TIMER_W-1:0] T_FLASH = TIMER_W'(FLASH_HALF - 1);
    // EW green has run at least its minimum once the timer is at or below this.
    localparam logic [TIMER_W-1:0] EW_GAP  =
        TIMER_W'(EW_MAX_GREEN - EW_MIN_GREEN);

    function automatic logic [TIMER_W-1:0] dur_m1(phase_e p);
        case (p)
            NS_GREEN:             return T_NSG;
            EW_GREEN:             return T_EWG;
            NS_YELLOW, EW_YELLOW: return T_YEL;
            PED_WALK:             return T_WALK;
            FLASH:                return T_FLASH;
            default:              return T_ARED;
        endcase
    endfunction

    phase_e             state_q, state_d;
    logic               ped_pending_q, ped_pending_d;
    logic               ped_ack_q, ped_ack_d;
    logic               fault_q, fault_d;
    logic               flash_off;
    logic               enter_ped;
    logic               load;
    logic [TIMER_W-1:0] timer;
    logic               zero, expire;
    lights_t            lt;

    phase_timer #(
        .W       (TIMER_W),
        .RST_VAL (T_ARED)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .tick_i     (tick),
        .load_i     (load),
        .load_val_i (dur_m1(state_d)),
        .count_o    (timer),
        .zero_o     (zero),
        .expire_o   (expire)
    );

    assign lt = decode(state_q, flash_off);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ALL_RED_A: if (expire) state_d = NS_GREEN;
            // Rest-state exit: demand is honoured without waiting for tick.
            NS_GREEN:
                if (zero && (ew_car || ped_pending_q)) state_d = NS_YELLOW;
            NS_YELLOW: if (expire) state_d = ALL_RED_B;
            ALL_RED_B:
                if (expire) state_d = ped_pending_q ? PED_WALK : EW_GREEN;
            EW_GREEN:
                if (expire || (tick && timer <= EW_GAP && !ew_car))
                    state_d = EW_YELLOW;
            EW_YELLOW, PED_WALK: if (expire) state_d = ALL_RED_A;
`ifdef CONFLICT_MONITOR_EN
            FLASH: state_d = FLASH;
`endif
            default: state_d = ALL_RED_A;
        endcase

        fault_d = fault_q;
`ifdef CONFLICT_MONITOR_EN
        if ((lt.ns != RED && lt.ew != RED) ||
            !(state_q inside {ALL_RED_A, NS_GREEN, NS_YELLOW, ALL_RED_B,
                              EW_GREEN, EW_YELLOW, PED_WALK, FLASH})) begin
            fault_d = 1'b1;
            state_d = FLASH;
        end
`endif

        enter_ped     = (state_d == PED_WALK) && (state_q != PED_WALK);
        ped_ack_d     = enter_ped;
        ped_pending_d = ped_pending_q;
        if (ped_req && state_q != PED_WALK) ped_pending_d = 1'b1;
        if (enter_ped)                      ped_pending_d = 1'b0;

        // FLASH reloads itself every half-period to pace the toggle.
        load = (state_d != state_q) || (state_q == FLASH && expire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ALL_RED_A;
            ped_pending_q <= 1'b0;
            ped_ack_q     <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            ped_ack_q     <= ped_ack_d;
            fault_q       <= fault_d;
        end
    end

`ifdef CONFLICT_MONITOR_EN
    logic flash_off_q;

    always_ff @(posedge clk) begin
        if (!rst_n || state_q != FLASH)
            flash_off_q <= 1'b0;
        else if (expire)
            flash_off_q <= ~flash_off_q;
    end

    assign flash_off = flash_off_q;
`else
    assign flash_off = 1'b0;
`endif

    assign ns_light = lt.ns;
    assign ew_light = lt.ew;
    assign ped_walk = lt.walk;
    assign ped_ack  = ped_ack_q;
    assign phase    = state_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench: directed vector table, tick-gating sequence and
// randomized traffic against an elapsed-tick reference model.
module tb_intersection_scheduler;

    localparam int NS_MIN = 50;
    localparam int EW_MIN = 10;
    localparam int EW_MAX = 30;
    localparam int YEL    = 5;
    localparam int ARED   = 2;
    localparam int WALK   = 20;

    logic       clk = 1'b0;
    logic       rst_n, tick, ew_car, ped_req;
    logic [1:0] ns_light, ew_light;
    logic       ped_walk, ped_ack, fault;
    logic [2:0] phase;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    intersection_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .ew_car   (ew_car),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .ped_walk (ped_walk),
        .ped_ack  (ped_ack),
        .phase    (phase),
        .fault    (fault)
    );

    // Reference model: phase plus ticks elapsed inside it.
    int m_ph, m_n, m_pend, m_ack;

    function automatic int dur(int ph);
        case (ph)
            1:       return NS_MIN;
            2, 5:    return YEL;
            4:       return EW_MAX;
            6:       return WALK;
            default: return ARED;
        endcase
    endfunction

    function automatic logic [4:0] exp_lights(int ph);
        case (ph)
            1:       return {2'b11, 2'b01, 1'b0};
            2:       return {2'b10, 2'b01, 1'b0};
            4:       return {2'b01, 2'b11, 1'b0};
            5:       return {2'b01, 2'b10, 1'b0};
            6:       return {2'b01, 2'b01, 1'b1};
            default: return {2'b01, 2'b01, 1'b0};
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit t,
                              input bit c, input bit p);
        bit done, ex;
        int nxt;
        if (!r) begin
            m_ph = 0; m_n = 0; m_pend = 0; m_ack = 0;
            return;
        end
        done = (m_n >= dur(m_ph) - 1);
        ex   = done && t;
        nxt  = m_ph;
        case (m_ph)
            0: if (ex) nxt = 1;
            1: if (done && (c || m_pend != 0)) nxt = 2;
            2: if (ex) nxt = 3;
            3: if (ex) nxt = (m_pend != 0) ? 6 : 4;
            4: if (ex || (t && m_n >= EW_MIN - 1 && !c)) nxt = 5;
            default: if (ex) nxt = 0;
        endcase
        if (p && m_ph != 6) m_pend = 1;
        m_ack = (nxt == 6 && m_ph != 6) ? 1 : 0;
        if (m_ack != 0) m_pend = 0;
        if (nxt != m_ph) m_n = 0;
        else if (t && !done) m_n++;
        m_ph = nxt;
    endtask

    task automatic step(input bit r, input bit t, input bit c, input bit p);
        logic [10:0] got, exp;
        rst_n = r; tick = t; ew_car = c; ped_req = p;
        @(posedge clk);
        model_edge(r, t, c, p);
        #1;
        got = {ns_light, ew_light, ped_walk, ped_ack, phase, fault};
        exp = {exp_lights(m_ph), m_ack[0], 3'(m_ph), 1'b0};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL model t=%0t got=%b exp=%b (ns,ew,walk,ack,ph,flt)",
                     $time, got, exp);
        end
    endtask

    typedef struct {
        int       n;
        bit       rst, tk, car, ped;
        logic [2:0] ph;
        logic [1:0] ns, ew;
        bit       walk, ack;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int cnt;
        bit done;
        bit car, ped, r;

        rst_n = 1'b0; tick = 1'b1; ew_car = 1'b0; ped_req = 1'b0;
        m_ph = 0; m_n = 0; m_pend = 0; m_ack = 0;

        tbl = '{
            '{3,   0,1,0,0, 3'd0, 2'b01,2'b01, 0,0},
            '{1,   1,1,0,0, 3'd0, 2'b01,2'b01, 0,0},
            '{200, 1,1,0,0, 3'd1, 2'b11,2'b01, 0,0},
            '{5,   1,1,1,0, 3'd2, 2'b10,2'b01, 0,0},
            '{2,   1,1,1,0, 3'd3, 2'b01,2'b01, 0,0},
            '{30,  1,1,1,0, 3'd4, 2'b01,2'b11, 0,0},
            '{5,   1,1,1,0, 3'd5, 2'b01,2'b10, 0,0},
            '{2,   1,1,1,0, 3'd0, 2'b01,2'b01, 0,0},
            '{50,  1,1,1,0, 3'd1, 2'b11,2'b01, 0,0},
            '{5,   1,1,1,0, 3'd2, 2'b10,2'b01, 0,0},
            '{2,   1,1,1,0, 3'd3, 2'b01,2'b01, 0,0},
            '{3,   1,1,1,0, 3'd4, 2'b01,2'b11, 0,0},
            '{7,   1,1,0,0, 3'd4, 2'b01,2'b11, 0,0},
            '{5,   1,1,0,0, 3'd5, 2'b01,2'b10, 0,0},
            '{2,   1,1,0,0, 3'd0, 2'b01,2'b01, 0,0},
            '{60,  1,1,0,0, 3'd1, 2'b11,2'b01, 0,0},
            '{1,   1,1,1,1, 3'd2, 2'b10,2'b01, 0,0},
            '{4,   1,1,1,0, 3'd2, 2'b10,2'b01, 0,0},
            '{2,   1,1,1,0, 3'd3, 2'b01,2'b01, 0,0},
            '{1,   1,1,1,0, 3'd6, 2'b01,2'b01, 1,1},
            '{19,  1,1,0,1, 3'd6, 2'b01,2'b01, 1,0},
            '{2,   1,1,0,0, 3'd0, 2'b01,2'b01, 0,0},
            '{60,  1,1,0,0, 3'd1, 2'b11,2'b01, 0,0}
        };

        foreach (tbl[k]) begin
            for (int j = 0; j < tbl[k].n; j++) begin
                step(tbl[k].rst, tbl[k].tk, tbl[k].car, tbl[k].ped);
                tests++;
                if ({ns_light, ew_light, ped_walk, ped_ack, phase} !==
                    {tbl[k].ns, tbl[k].ew, tbl[k].walk, tbl[k].ack,
                     tbl[k].ph}) begin
                    fails++;
                    $display("FAIL vec row=%0d cyc=%0d got=%b%b%b%b%b exp=%b%b%b%b%b",
                             k, j, ns_light, ew_light, ped_walk, ped_ack,
                             phase, tbl[k].ns, tbl[k].ew, tbl[k].walk,
                             tbl[k].ack, tbl[k].ph);
                end
            end
        end

        // Tick every 4th cycle: yellow must span 20 clocks.
        cnt = 0;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            step(1, (i % 4) == 0, i >= 8, 0);
            if (phase == 3'd2) cnt++;
            else if (cnt > 0) done = 1;
        end
        tests++;
        if (!done || cnt != 20) begin
            fails++;
            $display("FAIL tick_gate yellow_cycles got=%0d exp=20 ended=%0d",
                     cnt, done);
        end

        // Mid-phase reset pulse.
        step(1, 1, 1, 0);
        step(0, 1, 1, 1);
        tests++;
        if (phase !== 3'd0 || ns_light !== 2'b01 || ew_light !== 2'b01) begin
            fails++;
            $display("FAIL mid_reset got ph=%0d ns=%b ew=%b exp ph=0 ns=01 ew=01",
                     phase, ns_light, ew_light);
        end
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        tests++;
        if (phase !== 3'd1) begin
            fails++;
            $display("FAIL post_reset_ns got ph=%0d exp=1", phase);
        end

        // Randomized traffic against the reference model.
        car = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) car = ~car;
            ped = ($urandom_range(0, 59) == 0);
            r   = ($urandom_range(0, 999) != 0);
            step(r, $urandom_range(0, 3) != 0, car, ped);
        end

        tests++;
        if (fault !== 1'b0) begin
            fails++;
            $display("FAIL fault_tied got=%b exp=0", fault);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
